// File: rtl/mem_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single memory port with LAT-cycle read latency.
// Arbitration is round-robin by default; define MEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority.
module mem_arbiter #(
    parameter int LAT    = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,

    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DMA_XFER = 2'd2
    } state_t;

    // A read spends LAT cycles with mem_re high; cnt counts down to the completion cycle.
    localparam logic [2:0] RD_CNT = 3'(LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic              cpu_wins;
    logic              xfer;
    logic              done;
    logic              owner_we;
    logic [DATA_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign cpu_wins = cpu_req;
`else
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    logic last_owner;

    // CPU wins when alone, or on a tie if the DMA was the last one served.
    assign cpu_wins = cpu_req && (!dma_req || (last_owner == OWN_DMA));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWN_DMA;
        end else if (done) begin
            last_owner <= (state == CPU_XFER) ? OWN_CPU : OWN_DMA;
        end
    end
`endif

    assign xfer = (state == CPU_XFER) || (state == DMA_XFER);
    assign done = xfer && (cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (cpu_wins) begin
                    state_nxt = CPU_XFER;
                    cnt_nxt   = cpu_we ? 3'd0 : RD_CNT;
                end else if (dma_req) begin
                    state_nxt = DMA_XFER;
                    cnt_nxt   = dma_we ? 3'd0 : RD_CNT;
                end
            end
            CPU_XFER, DMA_XFER: begin
                if (cnt == 3'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // The owner's request lines are held stable, so the memory port follows them directly.
    always_comb begin
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        case (state)
            CPU_XFER: begin
                owner_we    = cpu_we;
                owner_addr  = cpu_addr;
                owner_wdata = cpu_wdata;
            end
            DMA_XFER: begin
                owner_we    = dma_we;
                owner_addr  = dma_addr;
                owner_wdata = dma_wdata;
            end
            default: begin
                owner_we    = 1'b0;
                owner_addr  = '0;
                owner_wdata = '0;
            end
        endcase
    end

    assign mem_addr  = owner_addr;
    assign mem_wdata = owner_wdata;
    assign mem_we    = xfer && owner_we;
    assign mem_re    = xfer && !owner_we;

    assign cpu_stall = cpu_req && !((state == CPU_XFER) && (cnt == 3'd0));
    assign dma_ack   = (state == DMA_XFER) && (cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (done && !owner_we) begin
            if (state == CPU_XFER) begin
                cpu_rdata_q <= mem_rdata;
            end else begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=2 main instance plus LAT=1 and LAT=7 latency instances.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = '0;

    logic        p1_req = 1'b0, p7_req = 1'b0;
    logic [31:0] p1_cpu_rdata, p7_cpu_rdata, p1_dma_rdata, p7_dma_rdata;
    logic        p1_stall, p7_stall, p1_ack, p7_ack;
    logic [31:0] p1_mem_addr, p7_mem_addr, p1_mem_wdata, p7_mem_wdata;
    logic        p1_mem_we, p7_mem_we, p1_mem_re, p7_mem_re;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rr_addr [8];
    logic        rr_we   [8];

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset),
        .cpu_req(p1_req), .cpu_we(1'b0), .cpu_addr(32'h60), .cpu_wdata(32'h0),
        .cpu_rdata(p1_cpu_rdata), .cpu_stall(p1_stall),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(p1_dma_rdata), .dma_ack(p1_ack),
        .mem_addr(p1_mem_addr), .mem_wdata(p1_mem_wdata), .mem_we(p1_mem_we), .mem_re(p1_mem_re),
        .mem_rdata(32'h11112222)
    );

    mem_arbiter #(.LAT(7)) dut_lat7 (
        .clk(clk), .reset(reset),
        .cpu_req(p7_req), .cpu_we(1'b0), .cpu_addr(32'h70), .cpu_wdata(32'h0),
        .cpu_rdata(p7_cpu_rdata), .cpu_stall(p7_stall),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
        .dma_rdata(p7_dma_rdata), .dma_ack(p7_ack),
        .mem_addr(p7_mem_addr), .mem_wdata(p7_mem_wdata), .mem_we(p7_mem_we), .mem_re(p7_mem_re),
        .mem_rdata(32'h77778888)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        rr_addr = '{32'h0, 32'h100, 32'h0, 32'h100, 32'h0, 32'h100, 32'h0, 32'h100};
`else
        rr_addr = '{32'h0, 32'h100, 32'h0, 32'h200, 32'h0, 32'h100, 32'h0, 32'h200};
`endif
        rr_we = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        #1;
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_dma_ack", 32'(dma_ack), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dma_rdata", dma_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'h0);

        // CPU read, LAT=2
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hCAFEF00D;
        #1;
        check("rd_c1_re", 32'(mem_re), 32'h0);
        check("rd_c1_stall", 32'(cpu_stall), 32'h1);
        step();
        check("rd_c2_re", 32'(mem_re), 32'h1);
        check("rd_c2_addr", mem_addr, 32'h10);
        check("rd_c2_stall", 32'(cpu_stall), 32'h1);
        step();
        check("rd_c3_re", 32'(mem_re), 32'h1);
        check("rd_c3_stall", 32'(cpu_stall), 32'h0);
        step();
        cpu_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        #1;
        check("rd_c4_re", 32'(mem_re), 32'h0);
        check("rd_c4_rdata", cpu_rdata, 32'hCAFEF00D);
        step();
        check("rd_c5_hold", cpu_rdata, 32'hCAFEF00D);
        check("rd_c5_dma_rdata", dma_rdata, 32'h0);

        // DMA write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        #1;
        check("wr_c1_we", 32'(mem_we), 32'h0);
        check("wr_c1_ack", 32'(dma_ack), 32'h0);
        step();
        check("wr_c2_we", 32'(mem_we), 32'h1);
        check("wr_c2_addr", mem_addr, 32'h20);
        check("wr_c2_wdata", mem_wdata, 32'h12345678);
        check("wr_c2_ack", 32'(dma_ack), 32'h1);
        check("wr_c2_re", 32'(mem_re), 32'h0);
        step();
        dma_req = 1'b0;
        #1;
        check("wr_c3_we", 32'(mem_we), 32'h0);
        check("wr_c3_ack", 32'(dma_ack), 32'h0);
        check("wr_c3_wdata", mem_wdata, 32'h0);

        // Simultaneous held requests after reset
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hAAAA0001;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'hBBBB0002;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            #1;
            check($sformatf("arb_addr_c%0d", c + 1), mem_addr, rr_addr[c]);
            check($sformatf("arb_we_c%0d", c + 1), 32'(mem_we), 32'(rr_we[c]));
            check($sformatf("arb_ack_c%0d", c + 1), 32'(dma_ack), 32'(rr_addr[c] == 32'h200));
            check($sformatf("arb_stall_c%0d", c + 1), 32'(cpu_stall), 32'(rr_addr[c] != 32'h100));
        end
        step();
        cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;

        // DMA read in flight while CPU requests
        do_reset();
        dma_req = 1'b1; dma_addr = 32'h30; mem_rdata = 32'hD0D0D0D0;
        #1;
        check("cx_c1_re", 32'(mem_re), 32'h0);
        step();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        check("cx_c2_stall", 32'(cpu_stall), 32'h1);
        check("cx_c2_addr", mem_addr, 32'h30);
        check("cx_c2_re", 32'(mem_re), 32'h1);
        step();
        check("cx_c3_stall", 32'(cpu_stall), 32'h1);
        check("cx_c3_ack", 32'(dma_ack), 32'h1);
        step();
        dma_req = 1'b0; mem_rdata = 32'hC0C0C0C0;
        #1;
        check("cx_c4_stall", 32'(cpu_stall), 32'h1);
        check("cx_c4_re", 32'(mem_re), 32'h0);
        check("cx_c4_dma_rdata", dma_rdata, 32'hD0D0D0D0);
        step();
        check("cx_c5_addr", mem_addr, 32'h40);
        check("cx_c5_stall", 32'(cpu_stall), 32'h1);
        step();
        check("cx_c6_stall", 32'(cpu_stall), 32'h0);
        check("cx_c6_ack", 32'(dma_ack), 32'h0);
        step();
        cpu_req = 1'b0;
        #1;
        check("cx_c7_cpu_rdata", cpu_rdata, 32'hC0C0C0C0);
        check("cx_c7_dma_rdata", dma_rdata, 32'hD0D0D0D0);

        // Reset mid CPU read
        step();
        cpu_req = 1'b1; cpu_addr = 32'h50; mem_rdata = 32'h55AA55AA;
        step();
        check("ra_c2_re", 32'(mem_re), 32'h1);
        reset = 1'b1;
        #1;
        check("ra_re_drop", 32'(mem_re), 32'h0);
        check("ra_addr", mem_addr, 32'h0);
        check("ra_cpu_rdata", cpu_rdata, 32'h0);
        check("ra_stall", 32'(cpu_stall), 32'h1);
        step();
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        check("ra_after_re", 32'(mem_re), 32'h0);
        check("ra_after_rdata", cpu_rdata, 32'h0);
        check("ra_after_stall", 32'(cpu_stall), 32'h0);

        // LAT=1 and LAT=7 CPU reads
        step();
        p1_req = 1'b1; p7_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) step();
            if (c == 3) p1_req = 1'b0;
            if (c == 9) p7_req = 1'b0;
            #1;
            check($sformatf("lat1_stall_c%0d", c), 32'(p1_stall), 32'(c == 1));
            check($sformatf("lat7_stall_c%0d", c), 32'(p7_stall), 32'(c < 8));
            if (c == 2) begin
                check("lat1_re_c2", 32'(p1_mem_re), 32'h1);
                check("lat1_addr_c2", p1_mem_addr, 32'h60);
                check("lat7_addr_c2", p7_mem_addr, 32'h70);
            end
            if (c == 3) check("lat1_rdata_c3", p1_cpu_rdata, 32'h11112222);
            if (c == 7) check("lat7_rdata_c7", p7_cpu_rdata, 32'h0);
            if (c == 8) check("lat7_re_c8", 32'(p7_mem_re), 32'h1);
            if (c == 9) begin
                check("lat7_rdata_c9", p7_cpu_rdata, 32'h77778888);
                check("lat7_re_c9", 32'(p7_mem_re), 32'h0);
            end
        end
        check("lat_aux_quiet",
              32'({p1_mem_we, p7_mem_we, p1_ack, p7_ack, |p1_dma_rdata, |p7_dma_rdata,
                   |p1_mem_wdata, |p7_mem_wdata}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning memory read latency in cycles (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit, the clock.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have ports cpu_req / cpu_we, input, 1 bit each: CPU access request / write select (from the multicycle controller's Mread|Mwrite and Mwrite).
REQ-005 The block SHALL have ports cpu_addr and cpu_wdata, input, 32 bits each, and cpu_rdata, output, 32 bits.
REQ-006 The block SHALL have port cpu_stall, output, 1 bit: CPU holds its controller step while high.
REQ-007 The block SHALL have ports dma_req / dma_we, input, 1 bit each; dma_addr and dma_wdata, input, 32 bits each; dma_rdata, output, 32 bits; dma_ack, output, 1 bit.
REQ-008 The block SHALL have ports mem_addr and mem_wdata, output, 32 bits each; mem_we and mem_re, output, 1 bit each; mem_rdata, input, 32 bits.

Function
REQ-009 The FSM SHALL have states IDLE, CPU_XFER and DMA_XFER, and a 3-bit latency counter cnt.
REQ-010 In IDLE with any request high, the FSM SHALL pick a winner, enter <winner>_XFER at the next edge and load cnt with 0 for a write or LAT-1 for a read.
REQ-011 On simultaneous requests, the winner SHALL be the requester not served last (round-robin via a last_owner flag, set to DMA at reset so the CPU wins first).
REQ-012 In a XFER state, mem_addr/mem_wdata/mem_we SHALL be driven from the owner; mem_re SHALL be high only for owner reads; cnt SHALL decrement each cycle while nonzero.
REQ-013 The cycle in a XFER state with cnt==0 SHALL be the completion cycle; at its closing edge the FSM SHALL return to IDLE and update last_owner.
REQ-014 In IDLE, mem_we and mem_re SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-015 A write SHALL assert mem_we for exactly one cycle; total latency SHALL be 2 cycles from a request seen in IDLE, and 1+LAT cycles for a read.
REQ-016 cpu_stall SHALL equal cpu_req AND NOT (state==CPU_XFER AND cnt==0), combinationally.
REQ-017 dma_ack SHALL be a single-cycle pulse, high exactly in the DMA completion cycle.
REQ-018 At a read completion edge, mem_rdata SHALL be latched into the owner's rdata register; cpu_rdata/dma_rdata SHALL hold that value until the owner's next read completes.
REQ-019 Requesters SHALL hold req, we, addr and wdata stable until completion; the block SHALL sample them combinationally during XFER.
REQ-020 Requests dropped mid-transfer SHALL NOT abort the transfer; it SHALL run to completion.
REQ-021 A request from the non-owner SHALL wait, without loss, until the next IDLE; there SHALL always be one IDLE cycle between transfers.

Reset
REQ-022 On reset, state SHALL become IDLE, cnt SHALL be 0, and last_owner SHALL be DMA.
REQ-023 On reset, cpu_rdata and dma_rdata SHALL be 0, dma_ack and mem_we/mem_re SHALL be 0, and cpu_stall SHALL follow REQ-016.
REQ-024 Reset asserted mid-transfer SHALL abort it immediately: mem_we/mem_re SHALL drop asynchronously, and no rdata SHALL be latched.

Configuration
REQ-025 With macro MEM_ARB_FIXED_PRIO_EN defined, the CPU SHALL always win simultaneous requests and last_owner SHALL be unused.
REQ-026 Without MEM_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-011.

Verification
REQ-027 LAT=2, CPU read addr 0x10 with mem_rdata=0xCAFEF00D -> mem_re high for 2 cycles, cpu_stall low in cycle 3, cpu_rdata=0xCAFEF00D from cycle 4.
REQ-028 DMA write addr 0x20 data 0x12345678 -> mem_we high for exactly 1 cycle with mem_addr=0x20 and mem_wdata=0x12345678, and a dma_ack pulse in that same cycle.
REQ-029 cpu_req and dma_req rise together after reset, both held -> order CPU, DMA, CPU, DMA, with one IDLE cycle between each; with MEM_ARB_FIXED_PRIO_EN -> CPU, CPU, CPU, and the DMA never served.
REQ-030 DMA read in progress while cpu_req rises -> cpu_stall high through the DMA transfer and the following IDLE, CPU transfer starts next, dma_rdata unaffected by the CPU read.
REQ-031 Reset pulsed in cnt==1 of a CPU read -> mem_re drops the same cycle, state returns to IDLE, cpu_rdata=0.
REQ-032 LAT=1 and LAT=7 CPU read -> completion at cycle 2 and cycle 8 respectively after the request.
